// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol width, the four control tokens and the serializer FSM states.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'b1010101011;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

endpackage

// File: rtl/tmds_hold_reg.sv
// Single-entry holding register between the TMDS encoder and the shift register.
module tmds_hold_reg
  import tmds_pkg::*;
#(
  parameter int WORD_W = TMDS_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tmds_in,
  input  logic              in_valid,
  input  logic              boundary,
  input  logic              take,
  output logic              in_ready,
  output logic [WORD_W-1:0] hold_q,
  output logic              hold_full
);

  logic accept;

  // A full hold can still accept on the word boundary because it drains on the same edge.
  assign in_ready = !hold_full || boundary;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
    end else if (take) begin
      hold_full <= accept;
    end else if (accept) begin
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= tmds_in;
    end
  end

endmodule

// File: rtl/tmds_serializer.sv
// 10:1 TMDS serializer, LSB first, inserting IDLE_WORD whenever the hold register is empty.
// Define TMDS_SER_DBG_EN to add the saturating uf_count underflow counter port.
module tmds_serializer
  import tmds_pkg::*;
#(
`ifdef TMDS_SER_DBG_EN
  parameter int                UF_CNT_W  = 16,
`endif
  parameter int                WORD_W    = TMDS_WORD_W,
  parameter logic [WORD_W-1:0] IDLE_WORD = CTRL_00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tmds_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              word_start,
  output logic              underflow
`ifdef TMDS_SER_DBG_EN
  ,
  output logic [UF_CNT_W-1:0] uf_count
`endif
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  ser_state_t        state, state_nx;
  logic [WORD_W-1:0] sr, sr_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic [WORD_W-1:0] hold_q;
  logic              hold_full;
  logic              boundary;
  logic              take;
  logic              load_idle;

  assign boundary  = (state == RUN) && (bit_cnt == LAST_BIT);
  assign take      = hold_full && ((state == IDLE) || boundary);
  assign load_idle = boundary && !hold_full;

  tmds_hold_reg #(
    .WORD_W(WORD_W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .tmds_in  (tmds_in),
    .in_valid (in_valid),
    .boundary (boundary),
    .take     (take),
    .in_ready (in_ready),
    .hold_q   (hold_q),
    .hold_full(hold_full)
  );

  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    bit_cnt_nx = bit_cnt;
    case (state)
      IDLE: begin
        if (hold_full) begin
          sr_nx      = hold_q;
          bit_cnt_nx = '0;
          state_nx   = RUN;
        end
      end
      RUN: begin
        if (boundary) begin
          sr_nx      = hold_full ? hold_q : IDLE_WORD;
          bit_cnt_nx = '0;
        end else begin
          sr_nx      = sr >> 1;
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      word_start <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nx;
      sr         <= sr_nx;
      bit_cnt    <= bit_cnt_nx;
      word_start <= take || load_idle;
      underflow  <= load_idle;
    end
  end

  // sr[0] is a flop output, so reset forces the line low without waiting for a clock.
  assign ser_out = sr[0];

`ifdef TMDS_SER_DBG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_count <= '0;
    end else if (load_idle && !(&uf_count)) begin
      uf_count <= uf_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_serializer.sv
// Scoreboard bench for tmds_serializer: accepted words are queued with their accept cycle,
// and a negedge monitor rebuilds the expected line from the word stream.
module tb_tmds_serializer;

  localparam logic [9:0] IDLE_W = 10'b1101010100;
`ifdef TMDS_SER_DBG_EN
  localparam int UFW    = 4;
  localparam int UF_MAX = (1 << UFW) - 1;
`else
  localparam int UF_MAX = 65535;
`endif

  typedef struct {
    logic [9:0] word;
    int         cyc;
  } acc_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] tmds_in  = '0;
  logic       in_ready;
  logic       ser_out;
  logic       word_start;
  logic       underflow;

`ifdef TMDS_SER_DBG_EN
  logic [UFW-1:0] uf_count;
  tmds_serializer #(.UF_CNT_W(UFW)) dut (
    .clk(clk), .rst_n(rst_n), .tmds_in(tmds_in), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .word_start(word_start),
    .underflow(underflow), .uf_count(uf_count)
  );
`else
  tmds_serializer dut (
    .clk(clk), .rst_n(rst_n), .tmds_in(tmds_in), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .word_start(word_start),
    .underflow(underflow)
  );
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  acc_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       running  = 1'b0;
  int         pos      = 0;
  logic [9:0] cur      = '0;
  int         uf_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Offer one symbol on the upcoming edge; queue it if the DUT will take it.
  task automatic drive(input logic v, input logic [9:0] d, output logic acc);
    acc_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    tmds_in  = d;
    acc = v && in_ready && rst_n;
    if (acc) begin
      e.word = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a word goes on the line every 10 bits once running; the head of the
  // queue is used only if it was accepted strictly before the load edge, else IDLE.
  always @(negedge clk) begin
    logic ews;
    logic euf;
    int   pend;
    acc_t head;
    if (!rst_n) begin
      check("rst_ser_out", ser_out, 0);
      check("rst_word_start", word_start, 0);
      check("rst_underflow", underflow, 0);
      check("rst_in_ready", in_ready, 1);
      exp_q.delete();
      running  = 1'b0;
      pos      = 0;
      uf_model = 0;
`ifdef TMDS_SER_DBG_EN
      check("rst_uf_count", uf_count, 0);
`endif
    end else begin
      ews = running ? (pos == 9) : (exp_q.size() > 0 && exp_q[0].cyc < cyc);
      euf = 1'b0;
      if (ews) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          head = exp_q.pop_front();
          cur  = head.word;
        end else begin
          cur = IDLE_W;
          euf = 1'b1;
        end
        running = 1'b1;
        pos     = 0;
      end else if (running) begin
        pos++;
      end
      pend = 0;
      foreach (exp_q[i]) if (exp_q[i].cyc <= cyc) pend++;
      if (euf && uf_model < UF_MAX) uf_model++;
      check("word_start", word_start, ews);
      check("underflow", underflow, euf);
      check("ser_out", ser_out, running ? cur[pos] : 1'b0);
      check("in_ready", in_ready, (pend == 0) || (running && pos == 9));
`ifdef TMDS_SER_DBG_EN
      check("uf_count", uf_count, uf_model);
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   got;
    int   waited;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (50) drive(1'b0, '0, acc);

    drive(1'b1, 10'b0000011111, acc);
    check("single_accept", acc, 1);
    repeat (25) drive(1'b0, '0, acc);

    got = 0;
    for (int i = 0; i < 2000 && got < 100; i++) begin
      drive(1'b1, 10'(got + 1), acc);
      if (acc) got++;
    end
    check("burst_words", got, 100);

    for (int i = 0; i < 600; i++) begin
      if (i % 97 == 50) repeat (12) drive(1'b0, '0, acc);
      drive($urandom_range(0, 3) != 0, 10'($urandom), acc);
    end

    // Long starvation drives the debug counter into saturation.
    repeat (250) drive(1'b0, '0, acc);

    waited = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 10'h3FF, acc);
      @(negedge clk);
      #1;
      waited++;
      if (i > 20 && running && pos == 4) break;
    end
    check("reach_bit4", (running && pos == 4) ? 1 : 0, 1);
    check("pre_rst_line", ser_out, 1);
    rst_n = 1'b0;
    #1;
    check("async_ser_out", ser_out, 0);
    check("async_in_ready", in_ready, 1);
    check("async_word_start", word_start, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (5) drive(1'b0, '0, acc);
    drive(1'b1, 10'b1010011001, acc);
    check("restart_accept", acc, 1);
    repeat (30) drive(1'b0, '0, acc);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tmds_serializer.md
Name: tmds_serializer

Overview:
- Single-clock 10:1 parallel-to-serial converter; sits directly downstream of the TMDS channel encoder.
- Accepts one 10-bit TMDS symbol per word via valid/ready and shifts it out LSB-first, one bit per clock.
- `clk` is the bit clock. The upstream encoder path runs on a clock enable derived from `in_ready`.
- A one-word holding register decouples the encoder from the shift timing. If no symbol is available, an idle control token is inserted automatically so the link never stalls.

Parameters:
- WORD_W, 10, symbol width in bits. Only 10 is supported; fixed by TMDS.
- IDLE_WORD, 10'b1101010100, symbol inserted on underflow (control token C1=0, C0=0).
- UF_CNT_W, 16, width of the saturating underflow counter (used only when the debug feature is enabled).

Ports:
- clk  in  1  bit clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronised externally.
- tmds_in  in  10  encoded symbol from the encoder; bit 0 is transmitted first.
- in_valid  in  1  tmds_in holds a valid symbol.
- in_ready  out  1  serializer can accept a symbol this cycle.
- ser_out  out  1  serial TMDS bit stream, driven straight from a flop.
- word_start  out  1  high while bit 0 of any word (data or inserted idle) is on ser_out.
- underflow  out  1  one-cycle pulse, coincident with word_start, when IDLE_WORD was inserted.
- uf_count  out  UF_CNT_W  saturating count of inserted idle words (present only with TMDS_SER_DBG_EN).

Behaviour:
- State: sr[9:0] shift register, bit_cnt 0..9, hold_q[9:0] plus hold_full, FSM {IDLE, RUN}.
- Reset values:
  - sr=0, ser_out=0, bit_cnt=0, hold_full=0, state=IDLE.
  - word_start=0, underflow=0, uf_count=0.
  - in_ready=1 during reset, since it is combinational from hold_full=0.
- Handshake:
  - in_ready = !hold_full || (state==RUN && bit_cnt==9). Purely combinational; does not depend on in_valid.
  - accept = in_valid && in_ready. On accept, hold_q <= tmds_in.
  - in_valid may drop without being accepted; no stickiness is required of the source.
- IDLE:
  - ser_out stays 0, word_start=0, no underflow counting.
  - When hold_full=1: next edge loads sr<=hold_q, bit_cnt<=0, state<=RUN, and hold_full<=accept.
- RUN:
  - ser_out = sr[0]. Each edge shifts sr right by 1 and increments bit_cnt.
  - At bit_cnt==9 (last bit on the line), the next edge sets bit_cnt<=0 and loads sr as follows:
    - If hold_full: sr<=hold_q; hold_full<=accept, with hold_q<=tmds_in if accepted the same cycle (drain and refill together).
    - Else: sr<=IDLE_WORD; underflow=1 for the next cycle.
    - A symbol accepted in that same cycle with an empty hold lands in hold_q and is not used for this load.
  - word_start = (state==RUN && bit_cnt==0), registered.
- Latency:
  - From an empty, idle block: tmds_in accepted at edge N appears as bit 0 on ser_out after edge N+1.
  - In RUN: the symbol appears at the next word boundary.
- Throughput: one symbol per 10 clocks. in_ready is high at most once per 10 cycles while hold is full.
- RUN is never exited except by reset. There is no way to stop the link.
- Reset mid-word: the partial word is abandoned, ser_out goes to 0 immediately (asynchronous), and hold is discarded.

Optional Feature:
- Macro: TMDS_SER_DBG_EN.
- Defined: the uf_count port exists and increments on each underflow, saturating at all-ones; it resets to 0.
- Undefined: there is no uf_count port and no counter logic. The underflow pulse is retained either way.

Decomposition:
- tmds_pkg holds:
  - TMDS_WORD_W=10.
  - The four control tokens: CTRL_00=10'b1101010100, CTRL_01=10'b0010101011, CTRL_10=10'b0101010100, CTRL_11=10'b1010101011.
  - The ser_state_t enum {IDLE, RUN}.
- One natural sub-module: tmds_hold_reg, the single-entry holding register with the ready/full logic. The shift, counter and FSM stay in the top module.

Test Plan:
- Reset, then in_valid=0 for 50 cycles -> ser_out=0, word_start=0, underflow=0, in_ready=1 throughout.
- Single word 10'b0000011111 accepted at edge N -> ser_out = 1,1,1,1,1,0,0,0,0,0 from the cycle after edge N+1; word_start on the first bit; then IDLE_WORD LSB-first (0,0,1,0,1,0,1,0,1,1) with underflow=1.
- Continuous valid with an incrementing pattern for 100 words -> bit-exact stream, no underflow, in_ready high exactly once per 10 cycles after the hold first fills.
- Source gaps: withhold in_valid for one full word period -> exactly one IDLE_WORD inserted, one underflow pulse, and uf_count +1 (with DBG_EN).
- Simultaneous drain and refill: in_valid held while hold_full at bit_cnt==9 -> the old hold word loads into sr and the new word is captured in the same edge; nothing is lost or duplicated.
- Assert rst_n low at bit_cnt=4 mid-word -> ser_out=0 asynchronously, hold_full=0; after release the block restarts in IDLE and counters are 0. With DBG_EN and UF_CNT_W=4, 20 underflows -> uf_count holds at 15.
